// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one bus between instruction fetch and data access
//   clk, rst            : clock, synchronous active-high reset
//   if_*                : fetch port (req/addr in, data/ack out)
//   mem_*               : data port (req/we/sel/addr/wdata in, rdata/ack out)
//   bus_*               : shared bus request (registered) and completion (rdata/ack in)
//   stallreq_if/mem_o   : requester still waiting; err_o flags a timed-out transfer with its ack
module bus_arbiter #(
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
  state_t state;
  logic last_fetch;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_nxt;
  logic grant_mem;
  logic fin;
  logic [31:0] cap;
  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;
  // data wins unless it won last time and fetch is also asking
  assign grant_mem = mem_req_i & (~if_req_i | last_fetch);
  assign cnt_nxt   = cnt + 1'b1;
  // transfer ends on ack, or when the wait count would reach all-ones
  assign fin       = bus_ack_i | (cnt_nxt == '1);
  assign cap       = bus_ack_i ? bus_rdata_i : 32'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_fetch  <= 1'b1;
      cnt         <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem || if_req_i) begin
            state       <= grant_mem ? DATA : FETCH;
            last_fetch  <= ~grant_mem;
            cnt         <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= grant_mem & mem_we_i;
            bus_sel_o   <= grant_mem ? mem_sel_i : 4'hF;
            bus_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
            bus_wdata_o <= grant_mem ? mem_wdata_i : 32'h0;
          end
        end
        DATA, FETCH: begin
          if (fin) begin
            state     <= DONE;
            bus_req_o <= 1'b0;
            err_o     <= ~bus_ack_i;
            if (state == DATA) begin
              mem_rdata_o <= cap;
              mem_ack_o   <= 1'b1;
            end else begin
              if_data_o <= cap;
              if_ack_o  <= 1'b1;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with directed transfers
module tb_bus_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic if_req_i = 0, mem_req_i = 0, mem_we_i = 0, bus_ack_i = 0;
  logic [31:0] if_addr_i = 0, mem_addr_i = 0, mem_wdata_i = 0, bus_rdata_i = 0;
  logic [3:0] mem_sel_i = 0;
  logic [31:0] if_data_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0] bus_sel_o;
  logic if_ack_o, mem_ack_o, bus_req_o, bus_we_o, stallreq_if_o, stallreq_mem_o, err_o;
  int tests = 0, fails = 0;
  typedef struct {logic f; logic [31:0] d; logic err; logic cd;} exp_t;
  exp_t q[$];

  bus_arbiter #(.TMO_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // monitor: every ack or err pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && (if_ack_o || mem_ack_o || err_o)) begin
      if (q.size() == 0) check("unexpected_ack", {if_ack_o, mem_ack_o, err_o}, 3'b000);
      else begin
        exp_t e;
        e = q.pop_front();
        check("ack_kind", {if_ack_o, mem_ack_o, err_o}, {e.f, ~e.f, e.err});
        if (e.cd) check("ack_data", e.f ? if_data_o : mem_rdata_o, e.d);
      end
    end
  end

  // bus responder: wait for a request, check fields stay stable, ack after waits cycles
  task automatic serve(input logic f, input int waits, input logic [31:0] rd, input logic [31:0] ea,
                       input logic ewe, input logic [3:0] esel, input logic [31:0] ewd);
    int n = 0;
    while (!bus_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bus_req_seen", bus_req_o, 1'b1);
    for (int i = 0; i <= waits; i++) begin
      check("bus_fields", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, {1'b1, ewe, esel, ea, ewd});
      if (f ? if_req_i : mem_req_i) check("stall_high", f ? stallreq_if_o : stallreq_mem_o, 1'b1);
      if (i == waits) begin
        bus_ack_i = 1;
        bus_rdata_i = rd;
      end
      @(negedge clk);
    end
    bus_ack_i = 0;
    check("bus_req_dropped", bus_req_o, 1'b0);
    if (f ? if_req_i : mem_req_i) check("stall_low_on_ack", f ? stallreq_if_o : stallreq_mem_o, 1'b0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
    check("rst_data", {if_data_o, mem_rdata_o}, 0);
    check("rst_flags", {if_ack_o, mem_ack_o, err_o, stallreq_if_o, stallreq_mem_o}, 0);
    rst = 0;
    // single fetch
    @(negedge clk);
    if_req_i = 1;
    if_addr_i = 32'h40;
    q.push_back('{1'b1, 32'h3401_1100, 1'b0, 1'b1});
    @(negedge clk);
    check("fetch_bus_req_n1", bus_req_o, 1'b1);
    serve(1'b1, 0, 32'h3401_1100, 32'h40, 1'b0, 4'hF, 32'h0);
    check("fetch_ack_n2", if_ack_o, 1'b1);
    if_req_i = 0;
    @(negedge clk);
    check("fetch_ack_one_cycle", if_ack_o, 1'b0);
    // contention after reset: data first, then alternate
    rst = 1;
    @(negedge clk);
    rst = 0;
    if_req_i = 1;
    if_addr_i = 32'h80;
    mem_req_i = 1;
    mem_we_i = 0;
    mem_sel_i = 4'hF;
    mem_addr_i = 32'h200;
    mem_wdata_i = 32'h1234_5678;
    q.push_back('{1'b0, 32'h1111_1111, 1'b0, 1'b1});
    serve(1'b0, 0, 32'h1111_1111, 32'h200, 1'b0, 4'hF, 32'h1234_5678);
    q.push_back('{1'b1, 32'h2222_2222, 1'b0, 1'b1});
    serve(1'b1, 0, 32'h2222_2222, 32'h80, 1'b0, 4'hF, 32'h0);
    q.push_back('{1'b0, 32'h3333_3333, 1'b0, 1'b1});
    serve(1'b0, 0, 32'h3333_3333, 32'h200, 1'b0, 4'hF, 32'h1234_5678);
    q.push_back('{1'b1, 32'h4444_4444, 1'b0, 1'b1});
    serve(1'b1, 0, 32'h4444_4444, 32'h80, 1'b0, 4'hF, 32'h0);
    if_req_i = 0;
    mem_req_i = 0;
    // write with three wait cycles
    @(negedge clk);
    mem_req_i = 1;
    mem_we_i = 1;
    mem_sel_i = 4'b0011;
    mem_addr_i = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF;
    q.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    serve(1'b0, 3, 32'hAAAA_AAAA, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    mem_req_i = 0;
    mem_we_i = 0;
    // spurious ack while idle
    @(negedge clk);
    bus_ack_i = 1;
    bus_rdata_i = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    bus_ack_i = 0;
    check("spurious_data", {if_data_o, mem_rdata_o}, {32'h4444_4444, 32'hAAAA_AAAA});
    check("spurious_bus", bus_req_o, 1'b0);
    // requester drops req while pending
    @(negedge clk);
    if_req_i = 1;
    if_addr_i = 32'h44;
    @(negedge clk);
    if_req_i = 0;
    q.push_back('{1'b1, 32'h5555_5555, 1'b0, 1'b1});
    serve(1'b1, 1, 32'h5555_5555, 32'h44, 1'b0, 4'hF, 32'h0);
    // timeout
    @(negedge clk);
    mem_req_i = 1;
    mem_sel_i = 4'hF;
    mem_addr_i = 32'h300;
    q.push_back('{1'b0, 32'h0, 1'b1, 1'b1});
    n = 0;
    while (!bus_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus_req_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, 15);
    check("timeout_ack_err", {mem_ack_o, err_o}, 2'b11);
    mem_req_i = 0;
    @(negedge clk);
    check("timeout_err_one_cycle", {mem_ack_o, err_o}, 2'b00);
    // reset mid-fetch then late ack
    if_req_i = 1;
    if_addr_i = 32'h48;
    @(negedge clk);
    check("midfetch_bus_req", bus_req_o, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    if_req_i = 0;
    bus_ack_i = 1;
    bus_rdata_i = 32'h9999_9999;
    repeat (2) @(negedge clk);
    bus_ack_i = 0;
    check("midrst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
    check("midrst_data", {if_data_o, mem_rdata_o}, 0);
    check("midrst_flags", {if_ack_o, mem_ack_o, err_o}, 0);
    repeat (2) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TMO_W, default 8, width of the bus-timeout counter; timeout limit is 2^TMO_W-1 cycles.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req_i  in  1  instruction-fetch request; held high until if_ack_o.
REQ-005 if_addr_i  in  32  fetch address.
REQ-006 if_data_o  out  32  fetched instruction, registered.
REQ-007 if_ack_o  out  1  one-cycle fetch-complete pulse.
REQ-008 mem_req_i  in  1  data-access request from MEM stage; held high until mem_ack_o.
REQ-009 mem_we_i  in  1  1=write, 0=read.
REQ-010 mem_sel_i  in  4  byte lane enables.
REQ-011 mem_addr_i  in  32  data address.
REQ-012 mem_wdata_i  in  32  write data.
REQ-013 mem_rdata_o  out  32  read data, registered.
REQ-014 mem_ack_o  out  1  one-cycle data-complete pulse.
REQ-015 bus_req_o / bus_we_o / bus_sel_o(4) / bus_addr_o(32) / bus_wdata_o(32)  out  shared single-port bus request, registered.
REQ-016 bus_rdata_i  in  32  bus read data, valid with bus_ack_i.
REQ-017 bus_ack_i  in  1  bus completion strobe.
REQ-018 stallreq_if_o  out  1  fetch waiting: if_req_i & ~if_ack_o (combinational).
REQ-019 stallreq_mem_o  out  1  data access waiting: mem_req_i & ~mem_ack_o (combinational).
REQ-020 err_o  out  1  one-cycle pulse, coincident with the ack of a timed-out transfer.

Function
REQ-021 FSM states IDLE, DATA, FETCH, DONE; encoding free.
REQ-022 IDLE: mem_req_i only -> DATA; if_req_i only -> FETCH; both -> requester not granted last (round-robin via last_grant flag); neither -> stay IDLE.
REQ-023 On grant edge: latch address/we/sel/wdata of winner into bus_* registers, bus_req_o=1 from next cycle, clear timeout counter, update last_grant.
REQ-024 Fetch grant drives bus_we_o=0, bus_sel_o=4'b1111, bus_wdata_o=0.
REQ-025 DATA/FETCH: bus_* held stable until bus_ack_i sampled high; counter increments each cycle without ack.
REQ-026 bus_ack_i in DATA/FETCH: capture bus_rdata_i into mem_rdata_o (DATA) or if_data_o (FETCH), bus_req_o=0, -> DONE.
REQ-027 DONE lasts exactly one cycle: matching ack_o=1, no new grant sampled, then -> IDLE; prevents re-grant of a requester still holding req.
REQ-028 Minimum latency: req sampled cycle N, bus_req_o high N+1, ack at N+1 -> ack_o high N+2; next grant earliest N+3.
REQ-029 Timeout: counter reaching 2^TMO_W-1 without ack -> bus_req_o=0, captured data=32'h0, -> DONE with ack_o and err_o both high.
REQ-030 Write transfers also capture bus_rdata_i; value is don't-care to requester.
REQ-031 bus_ack_i in IDLE or DONE ignored (no state or output change).
REQ-032 Requester dropping req while its transfer is pending: transfer completes, ack still pulses.
REQ-033 Data registers (if_data_o, mem_rdata_o) hold last value between transfers.

Reset
REQ-034 rst=1 at edge: state IDLE, all outputs 0, counter 0, last_grant=FETCH (data wins first conflict); overrides everything.
REQ-035 rst mid-transfer: transfer abandoned, no ack/err pulse; late bus_ack_i afterwards ignored.

Verification
REQ-036 Single fetch: if_req_i=1, if_addr_i=32'h0000_0040, bus_ack_i next cycle with 32'h3401_1100 -> bus_addr_o=0x40, bus_sel_o=4'hF, if_data_o=32'h3401_1100, if_ack_o one cycle, two cycles after request.
REQ-037 Contention: after reset both req high -> DATA granted first; hold both -> FETCH next; alternates while both held.
REQ-038 Write: mem_we_i=1, sel=4'b0011, addr 0x100, wdata 0xDEAD_BEEF, ack after 3 wait cycles -> bus signals stable 4 cycles, mem_ack_o one pulse, stallreq_mem_o high until ack.
REQ-039 Timeout with TMO_W=4: no bus_ack_i -> after 15 cycles bus_req_o=0, mem_ack_o=err_o=1 one cycle, mem_rdata_o=0.
REQ-040 Reset mid-FETCH then bus_ack_i -> no if_ack_o, state IDLE, all outputs 0.
REQ-041 Spurious bus_ack_i in IDLE -> no ack_o, data registers unchanged.
